// File: rtl/perceptron_bpred.sv
// Perceptron branch direction predictor: init sweep, speculative GHR with
// mispredict recovery, and a two-stage read-modify-write training pipeline.
`timescale 1ns/1ps
module perceptron_bpred #(
  parameter int unsigned HIST_LEN = 12,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned THRESH   = 37,
  parameter int unsigned SUM_W    = WEIGHT_W + 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                lu_valid,
  input  logic [31:0]         lu_pc,
  output logic                ready,
  output logic                pred_valid,
  output logic                pred_dir,
  output logic [SUM_W-1:0]    pred_sum,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                up_valid,
  input  logic [31:0]         up_pc,
  input  logic                up_dir,
  input  logic [SUM_W-1:0]    up_sum,
  input  logic [HIST_LEN-1:0] up_ghr,
  input  logic [1:0]          dbg_sel,
  output logic [31:0]         dbg_data
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned ROW_W = (HIST_LEN + 1) * WEIGHT_W;
  localparam int unsigned EXT_W = SUM_W - WEIGHT_W;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;

  // Row layout: bias in the low field, weight i in field i+1
  logic [ROW_W-1:0]    tbl_q [DEPTH];

  logic [HIST_LEN-1:0] ghr_q;

  logic                u1_valid_q;
  logic [IDX_W-1:0]    u1_idx_q;
  logic [ROW_W-1:0]    u1_row_q;
  logic                u1_dir_q;
  logic [HIST_LEN-1:0] u1_ghr_q;

  logic [31:0]         cnt_lookups_q;
  logic [31:0]         cnt_updates_q;
  logic [31:0]         cnt_mispred_q;
  logic [31:0]         cnt_train_q;

  logic                run_c;
  logic                accept_c;
  logic                upv_c;
  logic                mp_c;
  logic                near_c;
  logic                train_c;
  logic [IDX_W-1:0]    lu_idx_c;
  logic [IDX_W-1:0]    up_idx_c;
  logic [ROW_W-1:0]    lu_row_c;
  logic [ROW_W-1:0]    u0_row_c;
  logic [ROW_W-1:0]    u1_new_c;
  logic                fwd_c;
  logic [SUM_W-1:0]    sum_c;
  logic                dir_c;
  logic [SUM_W:0]      up_sum_x_c;
  logic [SUM_W:0]      up_abs_c;
  logic                wr_en_c;
  logic [IDX_W-1:0]    wr_idx_c;
  logic [ROW_W-1:0]    wr_row_c;
  logic                unused_pc_c;

  // Sign-extend one weight field to the sum width
  function automatic logic [SUM_W-1:0] sext_w(input logic [WEIGHT_W-1:0] w);
    return {{EXT_W{w[WEIGHT_W-1]}}, w};
  endfunction

  // Saturating +1/-1 step of one weight field
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w,
                                                   input logic inc);
    logic [WEIGHT_W:0] r;
    r = {w[WEIGHT_W-1], w} + (inc ? (WEIGHT_W+1)'(1) : {(WEIGHT_W+1){1'b1}});
    if (r[WEIGHT_W] != r[WEIGHT_W-1]) begin
      return r[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}};
    end
    return r[WEIGHT_W-1:0];
  endfunction

  assign unused_pc_c = ^{lu_pc[31:IDX_W+2], lu_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};

  assign run_c    = (state_q == ST_RUN);
  assign accept_c = run_c & lu_valid & ~stall;
  assign upv_c    = run_c & up_valid;
  assign lu_idx_c = lu_pc[IDX_W+1:2];
  assign up_idx_c = up_pc[IDX_W+1:2];

  // Mispredict when the returned sum's sign disagrees with the resolved direction
  assign mp_c       = upv_c & (~up_sum[SUM_W-1] != up_dir);
  assign up_sum_x_c = {up_sum[SUM_W-1], up_sum};
  assign up_abs_c   = up_sum[SUM_W-1] ? ((SUM_W+1)'(0) - up_sum_x_c) : up_sum_x_c;
  assign near_c     = (up_abs_c <= (SUM_W+1)'(THRESH));
  assign train_c    = upv_c & (mp_c | near_c);

  // Lookup sees the table as of the start of the cycle (no bypass from U1)
  assign lu_row_c = tbl_q[lu_idx_c];

  // Perceptron dot product over the row addressed by the lookup PC
  always_comb begin
    sum_c = sext_w(lu_row_c[WEIGHT_W-1:0]);
    for (int unsigned i = 0; i < HIST_LEN; i++) begin
      if (ghr_q[i]) sum_c = sum_c + sext_w(lu_row_c[(i+1)*WEIGHT_W +: WEIGHT_W]);
      else          sum_c = sum_c - sext_w(lu_row_c[(i+1)*WEIGHT_W +: WEIGHT_W]);
    end
  end

  assign dir_c = ~sum_c[SUM_W-1];

  // U0 read, forwarding the row U1 is about to write to the same index
  assign fwd_c    = u1_valid_q && (u1_idx_q == up_idx_c);
  assign u0_row_c = fwd_c ? u1_new_c : tbl_q[up_idx_c];

  // U1 training: bias moves by t, weight i moves by t*x_i, all saturating
  always_comb begin
    u1_new_c = u1_row_q;
    u1_new_c[WEIGHT_W-1:0] = sat_step(u1_row_q[WEIGHT_W-1:0], u1_dir_q);
    for (int unsigned i = 0; i < HIST_LEN; i++) begin
      u1_new_c[(i+1)*WEIGHT_W +: WEIGHT_W] =
        sat_step(u1_row_q[(i+1)*WEIGHT_W +: WEIGHT_W], u1_dir_q == u1_ghr_q[i]);
    end
  end

  // Single write port shared by the init sweep and U1 write-back
  always_comb begin
    wr_en_c  = 1'b0;
    wr_idx_c = u1_idx_q;
    wr_row_c = u1_new_c;
    if (state_q == ST_INIT) begin
      wr_en_c  = 1'b1;
      wr_idx_c = sweep_q;
      wr_row_c = '0;
    end else if (u1_valid_q) begin
      wr_en_c  = 1'b1;
    end
  end

  // Weight table storage
  always_ff @(posedge clk) begin
    if (wr_en_c) tbl_q[wr_idx_c] <= wr_row_c;
  end

  // FSM state and sweep index register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // FSM next state: sweep all rows once, then run
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (&sweep_q) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Ready flag, high from the first RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready <= 1'b0;
    else        ready <= (state_d == ST_RUN);
  end

  // Prediction output registers; hold when no lookup is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_dir   <= 1'b0;
      pred_sum   <= '0;
      pred_ghr   <= '0;
    end else begin
      pred_valid <= accept_c;
      if (accept_c) begin
        pred_dir <= dir_c;
        pred_sum <= sum_c;
        pred_ghr <= ghr_q;
      end
    end
  end

  // Speculative GHR; mispredict recovery wins over the speculative shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ghr_q <= '0;
    else if (mp_c)     ghr_q <= {up_ghr[HIST_LEN-2:0], up_dir};
    else if (accept_c) ghr_q <= {ghr_q[HIST_LEN-2:0], dir_c};
  end

  // U0 -> U1 pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u1_valid_q <= 1'b0;
      u1_idx_q   <= '0;
      u1_row_q   <= '0;
      u1_dir_q   <= 1'b0;
      u1_ghr_q   <= '0;
    end else begin
      u1_valid_q <= train_c;
      if (train_c) begin
        u1_idx_q <= up_idx_c;
        u1_row_q <= u0_row_c;
        u1_dir_q <= up_dir;
        u1_ghr_q <= up_ghr;
      end
    end
  end

  // Event counters, wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_lookups_q <= '0;
      cnt_updates_q <= '0;
      cnt_mispred_q <= '0;
      cnt_train_q   <= '0;
    end else begin
      if (accept_c) cnt_lookups_q <= cnt_lookups_q + 32'd1;
      if (upv_c)    cnt_updates_q <= cnt_updates_q + 32'd1;
      if (mp_c)     cnt_mispred_q <= cnt_mispred_q + 32'd1;
      if (train_c)  cnt_train_q   <= cnt_train_q + 32'd1;
    end
  end

  // Debug counter select
  always_comb begin
    dbg_data = cnt_lookups_q;
    case (dbg_sel)
      2'd0:    dbg_data = cnt_lookups_q;
      2'd1:    dbg_data = cnt_updates_q;
      2'd2:    dbg_data = cnt_mispred_q;
      default: dbg_data = cnt_train_q;
    endcase
  end

endmodule

// File: tb/tb_perceptron_bpred.sv
// Scoreboard bench for perceptron_bpred with a behavioural table/GHR model.
`timescale 1ns/1ps
module tb_perceptron_bpred;

  localparam int unsigned HIST_LEN = 12;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned THRESH   = 37;
  localparam int unsigned SUM_W    = 12;
  localparam int          DEPTH    = 64;
  localparam int          NF       = 13;

  logic                clk = 1'b0;
  logic                reset;
  logic                stall;
  logic                lu_valid;
  logic [31:0]         lu_pc;
  logic                ready;
  logic                pred_valid;
  logic                pred_dir;
  logic [SUM_W-1:0]    pred_sum;
  logic [HIST_LEN-1:0] pred_ghr;
  logic                up_valid;
  logic [31:0]         up_pc;
  logic                up_dir;
  logic [SUM_W-1:0]    up_sum;
  logic [HIST_LEN-1:0] up_ghr;
  logic [1:0]          dbg_sel;
  logic [31:0]         dbg_data;

  always #5 clk = ~clk;

  perceptron_bpred #(
    .HIST_LEN(HIST_LEN), .IDX_W(IDX_W), .WEIGHT_W(WEIGHT_W),
    .THRESH(THRESH), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .lu_valid(lu_valid), .lu_pc(lu_pc),
    .ready(ready), .pred_valid(pred_valid), .pred_dir(pred_dir),
    .pred_sum(pred_sum), .pred_ghr(pred_ghr),
    .up_valid(up_valid), .up_pc(up_pc), .up_dir(up_dir),
    .up_sum(up_sum), .up_ghr(up_ghr),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  typedef struct {
    int                  sum;
    bit                  dir;
    logic [HIST_LEN-1:0] ghr;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model: table visible to lookups, table as seen by training, pending write
  int                  mt_lu [DEPTH][NF];
  int                  mt_up [DEPTH][NF];
  bit                  pend_v;
  int                  pend_idx;
  int                  pend_row [NF];
  logic [HIST_LEN-1:0] m_ghr;
  int unsigned         m_cnt [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int clamp_w(input int v);
    int hi = (1 << (WEIGHT_W - 1)) - 1;
    int lo = -(1 << (WEIGHT_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < NF; k++) begin
        mt_lu[r][k] = 0;
        mt_up[r][k] = 0;
      end
    end
    pend_v = 1'b0;
    pend_idx = 0;
    m_ghr = '0;
    for (int s = 0; s < 4; s++) m_cnt[s] = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit lu, input logic [31:0] pc, input bit st,
                            input bit uv, input logic [31:0] upc, input bit ud,
                            input int us, input logic [HIST_LEN-1:0] ug);
    bit   acc;
    bit   mp;
    bit   tr;
    int   li;
    int   ui;
    int   s;
    int   a;
    int   t;
    int   x;
    exp_t e;
    acc = lu && !st;
    e.sum = 0;
    e.dir = 1'b0;
    e.ghr = m_ghr;
    if (acc) begin
      li = int'(pc[IDX_W+1:2]);
      s = mt_lu[li][0];
      for (int i = 0; i < int'(HIST_LEN); i++) begin
        x = m_ghr[i] ? 1 : -1;
        s = s + x * mt_lu[li][i+1];
      end
      e.sum = s;
      e.dir = (s >= 0);
      exp_q.push_back(e);
      m_cnt[0]++;
    end
    mp = 1'b0;
    tr = 1'b0;
    if (uv) begin
      m_cnt[1]++;
      mp = ((us >= 0) != ud);
      a  = (us < 0) ? -us : us;
      tr = mp || (a <= int'(THRESH));
      if (mp) m_cnt[2]++;
      if (tr) m_cnt[3]++;
    end
    if (pend_v) begin
      for (int k = 0; k < NF; k++) mt_lu[pend_idx][k] = pend_row[k];
    end
    pend_v = 1'b0;
    if (tr) begin
      ui = int'(upc[IDX_W+1:2]);
      t  = ud ? 1 : -1;
      mt_up[ui][0] = clamp_w(mt_up[ui][0] + t);
      for (int i = 0; i < int'(HIST_LEN); i++) begin
        x = ug[i] ? 1 : -1;
        mt_up[ui][i+1] = clamp_w(mt_up[ui][i+1] + t * x);
      end
      for (int k = 0; k < NF; k++) pend_row[k] = mt_up[ui][k];
      pend_idx = ui;
      pend_v = 1'b1;
    end
    if (mp)       m_ghr = {ug[HIST_LEN-2:0], ud};
    else if (acc) m_ghr = {m_ghr[HIST_LEN-2:0], e.dir};
  endtask

  task automatic sample_pred();
    exp_t e;
    if (pred_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("pred_valid_spurious", 32'(pred_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pred_sum", 32'($signed(pred_sum)), 32'(e.sum));
        check_eq("pred_dir", 32'(pred_dir), 32'(e.dir));
        check_eq("pred_ghr", 32'(pred_ghr), 32'(e.ghr));
      end
    end else if (exp_q.size() != 0) begin
      check_eq("pred_valid_missing", 32'(pred_valid), 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drive_cycle(input bit lu, input logic [31:0] pc, input bit st,
                             input bit uv, input logic [31:0] upc, input bit ud,
                             input int us, input logic [HIST_LEN-1:0] ug);
    lu_valid = lu;
    lu_pc    = pc;
    stall    = st;
    up_valid = uv;
    up_pc    = upc;
    up_dir   = ud;
    up_sum   = us[SUM_W-1:0];
    up_ghr   = ug;
    model_step(lu, pc, st, uv, upc, ud, us, ug);
    @(posedge clk);
    #1;
    sample_pred();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0, '0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive_cycle(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 0, '0);
  endtask

  task automatic update(input logic [31:0] pc, input bit d, input int s,
                        input logic [HIST_LEN-1:0] g);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, pc, d, s, g);
  endtask

  task automatic check_ctrs(input string tag);
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      check_eq($sformatf("%s_ctr%0d", tag, s), dbg_data, m_cnt[s]);
    end
  endtask

  // Reset, optionally re-asserted mid-sweep, then count cycles until ready
  task automatic reset_and_init(input bit mid);
    int cycles;
    int bad;
    lu_valid = 1'b1; lu_pc = 32'h40; stall = 1'b0;
    up_valid = 1'b1; up_pc = 32'h40; up_dir = 1'b0; up_sum = '0; up_ghr = '0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_pred_valid", 32'(pred_valid), 32'd0);
    check_eq("rst_pred_dir", 32'(pred_dir), 32'd0);
    check_eq("rst_pred_sum", 32'(pred_sum), 32'd0);
    check_eq("rst_pred_ghr", 32'(pred_ghr), 32'd0);
    check_ctrs("rst");
    reset = 1'b1;
    if (mid) begin
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_eq("mid_ready", 32'(ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
    end
    cycles = 0;
    bad = 0;
    while (!ready && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pred_valid) bad++;
    end
    check_eq("init_cycles", 32'(cycles), 32'd64);
    check_eq("init_pred_valid", 32'(bad), 32'd0);
    lu_valid = 1'b0;
    up_valid = 1'b0;
    check_ctrs("init");
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; lu_valid = 1'b0; lu_pc = '0;
    up_valid = 1'b0; up_pc = '0; up_dir = 1'b0; up_sum = '0; up_ghr = '0;
    dbg_sel = 2'd0;

    reset_and_init(1'b0);

    // First lookup on a fresh table
    lookup(32'h40);
    check_eq("first_sum", 32'($signed(pred_sum)), 32'd0);
    check_eq("first_dir", 32'(pred_dir), 32'd1);
    check_eq("first_ghr", 32'(pred_ghr), 32'd0);
    lookup(32'h44);
    check_eq("ghr_after_first", 32'(pred_ghr), 32'h001);

    // Mispredicted not-taken branch trains row 16
    update(32'h40, 1'b0, 0, '0);
    idle(2);
    lookup(32'h40);
    check_eq("trained_sum", 32'($signed(pred_sum)), 32'hFFFF_FFF3);
    check_eq("trained_dir", 32'(pred_dir), 32'd0);
    dbg_sel = 2'd2; #1;
    check_eq("mispred_cnt", dbg_data, 32'd1);
    dbg_sel = 2'd3; #1;
    check_eq("train_cnt", dbg_data, 32'd1);
    check_ctrs("after_mp");

    // Back-to-back updates through the forwarding path
    for (int i = 0; i < 3; i++) update(32'h80, 1'b1, 0, '0);
    idle(2);
    lookup(32'h80);
    check_eq("fwd_sum", 32'($signed(pred_sum)), 32'd39);

    // Saturation: 200 taken updates in total
    for (int i = 0; i < 197; i++) update(32'h80, 1'b1, 0, '0);
    update(32'hFC, 1'b0, 0, '0);
    idle(2);
    lookup(32'h80);
    check_eq("sat_sum", 32'($signed(pred_sum)), 32'd1663);
    check_eq("sat_dir", 32'(pred_dir), 32'd1);

    // Threshold boundary
    update(32'hC0, 1'b1, 50, '0);
    check_ctrs("thr50");
    idle(2);
    lookup(32'hC0);
    check_eq("thr50_row", 32'($signed(pred_sum)), 32'd0);
    update(32'hC0, 1'b1, 37, '0);
    check_ctrs("thr37");
    update(32'hC0, 1'b1, 38, 12'h3C3);
    update(32'hC0, 1'b0, -37, 12'h0F0);
    check_ctrs("thr_more");
    idle(2);
    lookup(32'hC0);

    // Lookup coinciding with mispredict recovery
    drive_cycle(1'b1, 32'h04, 1'b0, 1'b1, 32'h08, 1'b1, -5, 12'h0A5);
    lookup(32'h0C);
    check_eq("recover_ghr", 32'(pred_ghr), 32'h14B);

    // Lookup during U1 write to the same row sees the old contents
    update(32'h10, 1'b1, 0, '0);
    lookup(32'h10);
    check_eq("no_bypass_sum", 32'($signed(pred_sum)), 32'd0);
    idle(1);
    lookup(32'h10);

    // Stalled lookup is dropped
    drive_cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 0, '0);
    check_eq("stall_valid", 32'(pred_valid), 32'd0);

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 120)) - 60,
                  12'($urandom));
    end
    idle(2);
    check_ctrs("random");

    // Reset asserted while running takes effect immediately
    lookup(32'h40);
    reset = 1'b0;
    #1;
    check_eq("run_rst_ready", 32'(ready), 32'd0);
    check_eq("run_rst_valid", 32'(pred_valid), 32'd0);

    reset_and_init(1'b1);
    lookup(32'h40);
    check_eq("resweep_sum", 32'($signed(pred_sum)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/perceptron_bpred.md
Name: perceptron_bpred

Overview:
- Parametrised perceptron direction predictor for the fetch stage: generalised history length, table depth and weight width.
- Adds what the current predictor lacks: real threshold training via an internal read-modify-write pipeline, an init sweep FSM, a speculative GHR with mispredict recovery, and per-prediction sum/history snapshots for execute to return on update.
- Sits beside the instruction memory. Fetch supplies the PC; execute supplies the resolved outcomes.

Parameters:
- HIST_LEN, 12: global history bits, which is also the number of non-bias weights.
- IDX_W, 6: table index width. Depth is 2^IDX_W rows, indexed by PC[IDX_W+1:2].
- WEIGHT_W, 8: signed two's-complement weight width.
- THRESH, 37: training threshold, floor(1.93*HIST_LEN+14).
- SUM_W, WEIGHT_W+4: signed sum width. It must be at least WEIGHT_W+clog2(HIST_LEN+1).

Ports:
- clk  in  1  Clock; every register samples on the rising edge.
- reset  in  1  Asynchronous, active-low: asserted at 0, clears state immediately, release is synchronised.
- stall  in  1  Fetch stall. While 1, no lookup is accepted.
- lu_valid  in  1  Lookup request.
- lu_pc  in  32  Lookup PC.
- ready  out  1  1 once the init sweep has completed.
- pred_valid  out  1  Prediction valid; one cycle after an accepted lookup.
- pred_dir  out  1  1 = taken.
- pred_sum  out  SUM_W  Perceptron sum, to be carried down the pipe.
- pred_ghr  out  HIST_LEN  GHR value used to compute this prediction.
- up_valid  in  1  Resolved branch update.
- up_pc  in  32  Branch PC.
- up_dir  in  1  Actual direction.
- up_sum  in  SUM_W  pred_sum returned from lookup.
- up_ghr  in  HIST_LEN  pred_ghr returned from lookup.
- dbg_sel  in  2  Debug counter select: 0 lookups, 1 updates, 2 mispredicts, 3 trainings.
- dbg_data  out  32  Selected counter value.

Behaviour:
- Reset values: ready=0, pred_valid=0, pred_dir=0, pred_sum=0, pred_ghr=0, GHR=0, all counters 0, FSM=INIT, sweep index=0.
- FSM INIT: write one all-zero row (bias plus HIST_LEN weights) per cycle, index 0 up to 2^IDX_W-1, then go to RUN. ready=1 from the first RUN cycle onward.
- While in INIT: lu_valid and up_valid are ignored; pred_valid stays 0; counters hold.
- A reset assertion during any state forces INIT asynchronously and restarts the sweep from index 0.
- Lookup is accepted when state=RUN, lu_valid=1 and stall=0.
  - Synchronous table read occurs in the accept cycle; outputs are registered in cycle N+1.
  - x_i = +1 if GHR[i]=1, else -1.
  - pred_sum = bias + sum over i of x_i*w_i, sign-extended to SUM_W.
  - pred_dir = (pred_sum >= 0).
  - pred_ghr = the GHR value before the shift.
- Outputs when no lookup is accepted: pred_valid=0 next cycle; pred_dir, pred_sum and pred_ghr hold their values.
- Speculative GHR: on accept, GHR <= {GHR[HIST_LEN-2:0], predicted dir}. Bit 0 is the newest.
- Misprediction: mp = up_valid & ((up_sum >= 0) != up_dir).
  - On mp, GHR <= {up_ghr[HIST_LEN-2:0], up_dir}.
  - This recovery has priority over a speculative shift in the same cycle. The prediction issued in that cycle is still output, with its pred_ghr being the pre-recovery value.
- Training condition: train = up_valid & (mp | |up_sum| <= THRESH), with |.| computed in SUM_W+1 bits.
- Training pipeline:
  - U0 (update cycle): read row[up_pc idx]; latch up_dir, up_ghr and the index.
  - U1 (next cycle): t = +1 if up_dir=1, else -1. bias += t; w_i += t*x_i, where x_i comes from up_ghr. Write the row back.
  - Each field saturates to [-(2^(WEIGHT_W-1)), 2^(WEIGHT_W-1)-1].
  - Throughput is one update per cycle; stall does not block updates.
- RMW hazard: when U1 writes index k and U0 reads index k in the same cycle, U0 must take U1's new row by forwarding. There is no stale-read loss.
- Lookup read and U1 write to the same index in the same cycle: the lookup sees the old row (no bypass).
- Counters: 32-bit, wrapping.
  - lookups increments per accepted lookup.
  - updates increments per up_valid in RUN.
  - mispredicts increments per mp.
  - trainings increments per train.
- dbg_data is combinational from dbg_sel.

Test Plan:
- Reset with HIST_LEN=12, IDX_W=6 → ready=0 for exactly 64 cycles after release, then ready=1. lu_valid held at 1 during INIT → pred_valid=0 throughout.
- After init, lookup at PC 0x40 → next cycle pred_valid=1, pred_sum=0, pred_dir=1, pred_ghr=0; the following cycle GHR=0x001.
- Update PC 0x40, up_dir=0, up_ghr=0, up_sum=0 (mispredict) → row 16 has bias=-1 and all weights=+1. A subsequent lookup with GHR=0 gives pred_sum=-13, pred_dir=0. Counters: mispredicts=1, trainings=1.
- 200 consecutive up_dir=1 updates to one PC with up_sum=0 (WEIGHT_W=8) → bias saturates at 127 and does not wrap. Back-to-back updates exercise forwarding: after the 3rd update bias=3.
- Update with up_sum=+50, up_dir=1 → no training (trainings unchanged, row unchanged). up_sum=+37, up_dir=1 → training occurs.
- Lookup accepted in the same cycle as a mispredict update with up_ghr=0x0A5, up_dir=1 → GHR=0x14B; the speculative shift is discarded. Asserting reset mid-sweep → ready=0 immediately and a fresh 64-cycle sweep follows release.
